// File: rtl/rr_arbiter_83_if.sv
// Purpose: handshake/bus bundle between requesters and rr_arbiter_83.
// Ports: en/req/done driven by the requester side (master), gnt/gnt_id/gnt_valid
//        (and timeout when GRANT_TIMEOUT_EN is defined) driven by the arbiter (slave).
interface rr_arbiter_83_if;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
`ifdef GRANT_TIMEOUT_EN
  logic       timeout;

  modport master (output en, req, done, input gnt, gnt_id, gnt_valid, timeout);
  modport slave  (input en, req, done, output gnt, gnt_id, gnt_valid, timeout);
`else
  modport master (output en, req, done, input gnt, gnt_id, gnt_valid);
  modport slave  (input en, req, done, output gnt, gnt_id, gnt_valid);
`endif
endinterface

// File: rtl/rr_arbiter_83.sv
// Purpose: 8-way round-robin arbiter, one-hot grant plus binary index, held until release.
// Latency: req to gnt exactly 1 cycle; release to gnt drop 1 cycle; at least one idle cycle between grants.
// Backpressure: owner holds the grant until done, request withdrawal or en low.
// Ports: clk, rst (sync, active-high), bus (rr_arbiter_83_if.slave: en, req, done in;
//        gnt, gnt_id, gnt_valid out; timeout out only with GRANT_TIMEOUT_EN).
// Option: define GRANT_TIMEOUT_EN to force release after MAX_HOLD grant cycles.
module rr_arbiter_83 #(
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  rr_arbiter_83_if.slave bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
    $error("rr_arbiter_83: MAX_HOLD must be in 2..256");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [7:0] gnt_q, gnt_nxt;
  logic [2:0] id_q, id_nxt;
  logic       vld_q, vld_nxt;

  logic       found;
  logic [2:0] pick;
  logic [2:0] idx;
  logic       owner_rel;
  logic       rel;
  logic       adv;

`ifdef GRANT_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD);
  logic [CW-1:0] cnt, cnt_nxt;
  logic          to_q, to_nxt;
`endif

  // Rotating priority scan: ptr, ptr+1, ... wrapping through 7 back to ptr-1.
  always_comb begin
    found = 1'b0;
    pick  = 3'd0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Owner-driven release (done or withdrawal) advances the pointer past the owner,
  // even if en drops in the same cycle; a pure en-low release leaves it alone.
  assign owner_rel = bus.done | ~bus.req[id_q];

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt_q;
    id_nxt    = id_q;
    vld_nxt   = vld_q;
    rel       = 1'b0;
    adv       = 1'b0;
`ifdef GRANT_TIMEOUT_EN
    cnt_nxt   = cnt;
    to_nxt    = 1'b0;
`endif
    case (state)
      IDLE: begin
        gnt_nxt = 8'h00;
        id_nxt  = 3'd0;
        vld_nxt = 1'b0;
`ifdef GRANT_TIMEOUT_EN
        cnt_nxt = '0;
`endif
        if (bus.en && found) begin
          state_nxt = GRANT;
          gnt_nxt   = 8'h01 << pick;
          id_nxt    = pick;
          vld_nxt   = 1'b1;
        end
      end
      GRANT: begin
        if (owner_rel || !bus.en) begin
          rel = 1'b1;
          adv = owner_rel;
        end
`ifdef GRANT_TIMEOUT_EN
        // Forced release only when nothing else releases this cycle.
        else if (cnt == CW'(MAX_HOLD - 1)) begin
          rel    = 1'b1;
          adv    = 1'b1;
          to_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
        if (rel) begin
          state_nxt = IDLE;
          gnt_nxt   = 8'h00;
          id_nxt    = 3'd0;
          vld_nxt   = 1'b0;
        end
        if (adv) begin
          ptr_nxt = id_q + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 3'd0;
      gnt_q <= 8'h00;
      id_q  <= 3'd0;
      vld_q <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
      cnt   <= '0;
      to_q  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gnt_q <= gnt_nxt;
      id_q  <= id_nxt;
      vld_q <= vld_nxt;
`ifdef GRANT_TIMEOUT_EN
      cnt   <= cnt_nxt;
      to_q  <= to_nxt;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = id_q;
  assign bus.gnt_valid = vld_q;
`ifdef GRANT_TIMEOUT_EN
  assign bus.timeout   = to_q;
`endif

endmodule
